// File: rtl/rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_if
// Request/grant bundle between N requesters and the round-robin arbiter.
//   req       : request vector, bit i = requester i wants the resource
//   done      : release strobe from the current grant holder
//   gnt       : registered one-hot grant, all-zero when idle
//   gnt_valid : high while any grant is held (|gnt)
//   gnt_id    : index of granted requester, holds last value while idle
//   timeout   : one-cycle pulse on forced release
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
    logic          timeout;

    modport master (
        output req, done,
        input  gnt, gnt_valid, gnt_id, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_valid, gnt_id, timeout
    );
endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: hands a registered one-hot grant to one of N
// requesters and holds it until the holder releases (done, or by dropping
// its request). After each release the winner gets lowest priority.
//
// Ports:
//   i_clk   : clock, all state on rising edge
//   i_rst_n : synchronous active-low reset
//   arb     : rr_arbiter_if.slave (req, done in; gnt, gnt_valid, gnt_id,
//             timeout out)
// Parameters:
//   N       : number of requesters (>= 2)
//   TIMEOUT : max grant length in cycles (>= 1), only with ARB_TIMEOUT_EN
// Build option:
//   ARB_TIMEOUT_EN : when defined, a grant held TIMEOUT cycles is forcibly
//                    released and timeout pulses for one cycle. When not
//                    defined, grants are held indefinitely and timeout = 0.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    rr_arbiter_if.slave  arb
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_gnt;
    logic [IW-1:0] r_gnt_id;
    logic [IW-1:0] r_ptr;

    logic          w_win_vld;
    logic [IW-1:0] w_win_id;
    logic [N-1:0]  w_win_oh;
    logic          w_rel_normal;
    logic          w_expire;
    logic          w_release;
    logic          w_take;
    logic [IW-1:0] w_ptr_nxt;

    // Rotating priority search: walk offsets from high to low so the
    // smallest offset from r_ptr is the last (and winning) assignment.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (arb.req[(int'(r_ptr) + off) % N]) begin
                w_win_vld = 1'b1;
                w_win_id  = IW'((int'(r_ptr) + off) % N);
            end
        end
    end

    always_comb begin
        w_win_oh = '0;
        for (int i = 0; i < N; i++) begin
            w_win_oh[i] = (int'(w_win_id) == i);
        end
    end

    // Holder releases on done or by withdrawing its own request.
    assign w_rel_normal = arb.done || !arb.req[r_gnt_id];
    assign w_ptr_nxt    = (r_gnt_id == IW'(N - 1)) ? '0 : r_gnt_id + 1'b1;

    // Next-state / control decode
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_rel_normal || w_expire) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
        end else if (w_take) begin
            r_gnt    <= w_win_oh;
            r_gnt_id <= w_win_id;
        end else if (w_release) begin
            r_gnt    <= '0;
            r_ptr    <= w_ptr_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    // r_cnt counts completed GRANT edges; expiry fires on the TIMEOUT-th.
    assign w_expire = (r_state == S_GRANT) && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            // A normal release on the expiry edge wins: no timeout pulse.
            r_timeout <= w_release && !w_rel_normal;
            if (r_state != S_GRANT || w_release) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign arb.timeout = r_timeout;
`else
    assign w_expire    = 1'b0;
    assign arb.timeout = 1'b0;
`endif

    assign arb.gnt       = r_gnt;
    assign arb.gnt_valid = |r_gnt;
    assign arb.gnt_id    = r_gnt_id;
endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
// Directed checks of rr_arbiter (N=4, TIMEOUT=8). Inputs change 1 ns after
// the rising edge; outputs are sampled at that same point, so each step()
// shows the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rr_arbiter_if #(.N(4)) arb_if ();

    rr_arbiter #(.N(4), .TIMEOUT(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .arb     (arb_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic [3:0] exp);
        chk({tag, ".gnt"}, 32'(arb_if.gnt), 32'(exp));
        chk({tag, ".vld"}, 32'(arb_if.gnt_valid), 32'(exp != 4'b0000));
    endtask

    logic [3:0] fair_seq [5];

    initial begin
        fair_seq[0] = 4'b0001; fair_seq[1] = 4'b0010; fair_seq[2] = 4'b0100;
        fair_seq[3] = 4'b1000; fair_seq[4] = 4'b0001;

        // Reset with all requesting
        rst_n = 1'b0; arb_if.req = 4'b1111; arb_if.done = 1'b0;
        step(); step();
        chk_gnt("rst", 4'b0000);
        chk("rst.id", 32'(arb_if.gnt_id), 32'd0);
        chk("rst.to", 32'(arb_if.timeout), 32'd0);

        rst_n = 1'b1;
        step();
        chk_gnt("first", 4'b0001);
        chk("first.id", 32'(arb_if.gnt_id), 32'd0);
        arb_if.done = 1'b1;
        step();
        chk_gnt("first_rel", 4'b0000);
        arb_if.done = 1'b0; arb_if.req = 4'b0000;
        step();

        // Single request, held three cycles, then done
        arb_if.req = 4'b0100;
        step();
        chk_gnt("single", 4'b0100);
        chk("single.id", 32'(arb_if.gnt_id), 32'd2);
        step(); step();
        chk_gnt("single_hold", 4'b0100);
        arb_if.done = 1'b1;
        step();
        chk_gnt("single_rel", 4'b0000);
        chk("single_rel.id", 32'(arb_if.gnt_id), 32'd2);
        arb_if.done = 1'b0; arb_if.req = 4'b0000;

        // Fairness from ptr=0, done held high (ignored while idle)
        rst_n = 1'b0; step(); rst_n = 1'b1;
        arb_if.req = 4'b1111; arb_if.done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_gnt($sformatf("fair%0d", k), fair_seq[k]);
            step();
            chk_gnt($sformatf("fair_gap%0d", k), 4'b0000);
        end
        arb_if.done = 1'b0; arb_if.req = 4'b0000;
        // ptr is now 1

        // Withdrawal of bit 3, wrap of ptr to 0
        arb_if.req = 4'b1000;
        step();
        chk_gnt("wd_g3", 4'b1000);
        chk("wd_g3.id", 32'(arb_if.gnt_id), 32'd3);
        arb_if.req = 4'b0000;
        step();
        chk_gnt("wd_rel", 4'b0000);
        arb_if.req = 4'b1001;
        step();
        chk_gnt("wrap_g0", 4'b0001);
        arb_if.done = 1'b1;
        step();
        chk_gnt("wrap_rel", 4'b0000);
        step();
        chk_gnt("wrap_g3", 4'b1000);
        step();
        arb_if.done = 1'b0; arb_if.req = 4'b0000;
        step();

        // Reset mid-grant; ptr must return to 0
        arb_if.req = 4'b0010;
        step();
        chk_gnt("mid_g1", 4'b0010);
        step();
        chk_gnt("mid_hold", 4'b0010);
        rst_n = 1'b0;
        step();
        chk_gnt("mid_rst", 4'b0000);
        chk("mid_rst.id", 32'(arb_if.gnt_id), 32'd0);
        rst_n = 1'b1; arb_if.req = 4'b0011;
        step();
        chk_gnt("mid_after", 4'b0001);

        // done together with a new request: release first, re-arbitrate next
        arb_if.done = 1'b1; arb_if.req = 4'b0011;
        step();
        chk_gnt("dn_rel", 4'b0000);
        step();
        chk_gnt("dn_next", 4'b0010);
        chk("dn_next.id", 32'(arb_if.gnt_id), 32'd1);
        step();
        arb_if.done = 1'b0; arb_if.req = 4'b0000;
        step();

        // Long hold with done=0
        arb_if.req = 4'b0001;
        step();
        chk_gnt("to_g", 4'b0001);
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 7; k++) begin
            step();
            chk_gnt($sformatf("to_hold%0d", k), 4'b0001);
            chk($sformatf("to_hold%0d.to", k), 32'(arb_if.timeout), 32'd0);
        end
        step();
        chk_gnt("to_exp", 4'b0000);
        chk("to_exp.to", 32'(arb_if.timeout), 32'd1);
        step();
        chk_gnt("to_regnt", 4'b0001);
        chk("to_regnt.to", 32'(arb_if.timeout), 32'd0);
`else
        for (int k = 0; k < 100; k++) begin
            step();
            chk_gnt($sformatf("hold%0d", k), 4'b0001);
            chk($sformatf("hold%0d.to", k), 32'(arb_if.timeout), 32'd0);
        end
`endif
        arb_if.req = 4'b0000;
        step();
        chk_gnt("end_rel", 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
